// File: rtl/ps2_host_tx_pkg.sv
// ============================================================================
// ps2_host_tx_pkg : shared FSM encoding, PS/2 command bytes and small helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_START   = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_ACK_REL = 3'd5
  } state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] DEV_ACK     = 8'hFA;

  // Falls 1..10 carry data/parity/stop; fall 11 is the device ack.
  localparam logic [3:0] FALL_STOP = 4'd9;
  localparam logic [3:0] FALL_ACK  = 4'd11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic [3:0] fall_inc(input logic [3:0] n);
    return (n >= FALL_ACK) ? FALL_ACK : n + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_input_filter.sv
// ============================================================================
// ps2_input_filter : 2-FF synchronizer plus stability filter for a PS/2 pin
// Revision 1.0
// ============================================================================
`default_nettype none

module ps2_input_filter #(
  parameter int CLOCK_FILTER = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic level
);

  localparam int CW = $clog2(CLOCK_FILTER + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Filtered level only follows the pin after CLOCK_FILTER consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(CLOCK_FILTER - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// ps2_host_tx : PS/2 host-to-device transmitter (inhibit, start, data, parity,
//               stop, device ack) driving open-drain enables
// Revision 1.0
// ============================================================================
`default_nettype none

module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLOCK_FILTER   = 24,
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_trigger,
  input  logic [7:0] send_byte,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic clk_lvl, dat_lvl, clk_fall;

  ps2_input_filter #(.CLOCK_FILTER(CLOCK_FILTER)) u_clk_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_in (ps2_clk_in),
    .level  (clk_lvl)
  );

  ps2_input_filter #(.CLOCK_FILTER(CLOCK_FILTER)) u_dat_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_in (ps2_dat_in),
    .level  (dat_lvl)
  );

  state_e             state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic               parity_q, parity_d;
  logic [3:0]         nfall_q, nfall_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               clk_oe_q, clk_oe_d;
  logic               dat_oe_q, dat_oe_d;
  logic               clk_prev_q, clk_prev_d;

  assign clk_prev_d = clk_lvl;
  assign clk_fall   = clk_prev_q & ~clk_lvl;

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    parity_d = parity_q;
    nfall_d  = nfall_q;
    cnt_d    = cnt_q + CNT_W'(1);
    busy_d   = busy_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        busy_d   = 1'b0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        // busy_q is still high during the done/error cycle, so a trigger there is ignored.
        if (send_trigger && !busy_q) begin
          byte_d   = send_byte;
          parity_d = odd_parity(send_byte);
          nfall_d  = '0;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (clk_fall) begin
          cnt_d   = '0;
          nfall_d = fall_inc(nfall_q);
          if (nfall_q < 4'd8) begin
            dat_oe_d = ~byte_q[nfall_q[2:0]];
          end else if (nfall_q < FALL_STOP) begin
            dat_oe_d = ~parity_q;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          cnt_d   = '0;
          nfall_d = fall_inc(nfall_q);
          if (!dat_lvl) begin
            state_d = ST_ACK_REL;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ACK_REL: begin
        if (clk_lvl && dat_lvl) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_START || state_q == ST_SHIFT || state_q == ST_ACK ||
         state_q == ST_ACK_REL) && !clk_fall && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b1;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_q     <= '0;
      parity_q   <= 1'b0;
      nfall_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      nfall_q    <= nfall_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// tb_ps2_host_tx : directed bench with a PS/2 device model for ps2_host_tx
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;

  localparam int FILT = 24;
  localparam int INH  = 200;
  localparam int TMO  = 5000;
  localparam int H    = 80;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send_trigger;
  logic [7:0] send_byte;
  logic       busy, done, error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low, dev_dat_low;
  logic       clk_line, dat_line;

  assign clk_line = !(ps2_clk_oe || dev_clk_low);
  assign dat_line = !(ps2_dat_oe || dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLOCK_FILTER   (FILT),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .send_trigger (send_trigger),
    .send_byte    (send_byte),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .ps2_clk_in   (clk_line),
    .ps2_dat_in   (dat_line),
    .ps2_clk_oe   (ps2_clk_oe),
    .ps2_dat_oe   (ps2_dat_oe)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int done_cnt = 0, err_cnt = 0, both_cnt = 0, run = 0, last_run = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
    if (ps2_clk_oe) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic trigger(input logic [7:0] b);
    @(negedge clk);
    send_byte    = b;
    send_trigger = 1'b1;
    @(negedge clk);
    send_trigger = 1'b0;
  endtask

  task automatic dev_wait_start(output logic started);
    started = 1'b0;
    for (int k = 0; k < INH + 100; k++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_dat_oe) begin
        started = 1'b1;
        break;
      end
    end
  endtask

  task automatic dev_clock(output logic b);
    repeat (H) @(posedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(posedge clk);
    b = dat_line;
    dev_clk_low = 1'b0;
  endtask

  task automatic dev_ack(input logic ack);
    repeat (H / 2) @(posedge clk);
    dev_dat_low = ack;
    repeat (H / 2) @(posedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(posedge clk);
    dev_clk_low = 1'b0;
    repeat (H / 2) @(posedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b, input logic ack, input logic glitch,
                           output logic [9:0] bits, output logic started);
    logic bt;
    bits = '0;
    trigger(b);
    dev_wait_start(started);
    if (started) begin
      for (int i = 0; i < 10; i++) begin
        if (glitch && i == 3) begin
          repeat (20) @(posedge clk);
          dev_clk_low = 1'b1;
          repeat (10) @(posedge clk);
          dev_clk_low = 1'b0;
        end
        if (glitch && i == 5) trigger(8'h00);
        dev_clock(bt);
        bits[i] = bt;
      end
      dev_ack(ack);
    end
    repeat (200) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       ack;
    logic       glitch;
    logic [9:0] exp_bits;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    logic       started;
    int         d0, e0, waited;
    logic       bt;

    // {stop, parity, data[7:0]} as seen on DATA at each device rising edge
    vecs[0] = '{8'hED, 1'b1, 1'b0, 10'b11_1110_1101, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 10'b11_0000_0000, 1, 0};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 10'b10_0000_0001, 1, 0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 10'b11_1111_1111, 0, 1};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 10'b11_1111_1111, 1, 0};
    vecs[5] = '{8'hA5, 1'b1, 1'b1, 10'b11_1010_0101, 1, 0};

    rst_n        = 1'b0;
    send_trigger = 1'b0;
    send_byte    = 8'h00;
    dev_clk_low  = 1'b0;
    dev_dat_low  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      run_frame(vecs[v].tx, vecs[v].ack, vecs[v].glitch, bits, started);
      @(negedge clk);
      chk($sformatf("v%0d_start", v), started, 1);
      chk($sformatf("v%0d_inhibit_ge", v), last_run >= INH, 1);
      chk($sformatf("v%0d_bits", v), bits, vecs[v].exp_bits);
      chk($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
      chk($sformatf("v%0d_error", v), err_cnt - e0, vecs[v].exp_err);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_oe", v), {ps2_clk_oe, ps2_dat_oe}, 0);
    end

    // Device stops clocking after the start bit
    d0 = done_cnt;
    e0 = err_cnt;
    trigger(8'h55);
    dev_wait_start(started);
    chk("tmo_start", started, 1);
    waited = -1;
    for (int k = 1; k <= TMO + 500; k++) begin
      @(negedge clk);
      if (error) begin
        waited = k;
        break;
      end
    end
    chk("tmo_window", (waited >= TMO - 5) && (waited <= TMO + 5), 1);
    chk("tmo_busy_in_pulse", busy, 1);
    chk("tmo_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    repeat (2) @(negedge clk);
    chk("tmo_busy_after", busy, 0);
    chk("tmo_no_done", done_cnt - d0, 0);
    chk("tmo_err_once", err_cnt - e0, 1);

    // Async reset in the middle of bit 4 (0x0C has bit4 = 0, so DATA is driven low)
    trigger(8'h0C);
    dev_wait_start(started);
    for (int i = 0; i < 4; i++) dev_clock(bt);
    repeat (H) @(posedge clk);
    dev_clk_low = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_bit4_dat_oe", ps2_dat_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_clk_oe", ps2_clk_oe, 0);
    chk("arst_dat_oe", ps2_dat_oe, 0);
    chk("arst_busy", busy, 0);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    d0 = done_cnt;
    run_frame(8'h3C, 1'b1, 1'b0, bits, started);
    chk("post_rst_start", started, 1);
    chk("post_rst_bits", bits, 10'b11_0011_1100);
    chk("post_rst_done", done_cnt - d0, 1);

    chk("never_done_and_error", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
